// File: rtl/cpu_pkg.sv
// Shared opcode constants, FSM state type and instruction layout for the
// sequential ALU controller.
package cpu_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned REG_AW = 3;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LDI  = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  // imm[9:0] overlays ra, rb and the low nibble
  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [3:0] rsvd;
  } instr_t;

  function automatic logic [WORD_W-1:0] ldi_value(input instr_t i);
    return {6'b0, i.ra, i.rb, i.rsvd};
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8x16 register file: two combinational read ports, a debug read port and
// one synchronous write port. r0 always reads zero.
module alu_regfile
  import cpu_pkg::*;
#(
  parameter int unsigned NREGS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [WORD_W-1:0] rdata_a_c,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [WORD_W-1:0] rdata_b_c,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [WORD_W-1:0] dbg_data_c
);

  logic [WORD_W-1:0] mem [NREGS];

  // Writes to r0 are dropped so it stays at its reset value of zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a_c  = mem[raddr_a];
  assign rdata_b_c  = mem[raddr_b];
  assign dbg_data_c = mem[dbg_addr];

endmodule

// File: rtl/alu_seq.sv
// Four-state instruction sequencer driving an external combinational ALU:
// IDLE accepts, READ fetches operands, EXEC captures the result, WB writes.
module alu_seq
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic [2:0]        ALU_sel,
  input  logic [DATA_W-1:0] alu_out,
  output logic              done,
  output logic              illegal,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            state_q, state_d;
  instr_t            instr_q, instr_d;
  logic [DATA_W-1:0] reg1_q, reg1_d, reg2_q, reg2_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [2:0]        sel_q, sel_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic [WORD_W-1:0] rdata_a, rdata_b;
  logic              wb_we;

  assign wb_we = (state_q == WB) && !instr_q.op[2];

  alu_regfile #(.NREGS(NREGS)) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (wb_we),
    .waddr      (instr_q.rd),
    .wdata      (result_q),
    .raddr_a    (instr_q.ra),
    .rdata_a_c  (rdata_a),
    .raddr_b    (instr_q.rb),
    .rdata_b_c  (rdata_b),
    .dbg_addr   (dbg_addr),
    .dbg_data_c (dbg_data)
  );

  // Next-state and next-output logic; ALU-facing outputs are zero outside EXEC
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    reg1_d    = '0;
    reg2_d    = '0;
    sel_d     = '0;
    result_d  = result_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_d = instr_t'(instr);
          state_d = READ;
        end
      end
      READ: begin
        reg1_d  = rdata_a;
        reg2_d  = rdata_b;
        sel_d   = (instr_q.op == OP_LDI) ? OP_ADD : instr_q.op;
        state_d = EXEC;
      end
      EXEC: begin
        result_d  = (instr_q.op == OP_LDI) ? ldi_value(instr_q) : alu_out;
        done_d    = !instr_q.op[2];
        illegal_d = instr_q.op[2];
        state_d   = WB;
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      reg1_q    <= '0;
      reg2_q    <= '0;
      sel_q     <= '0;
      result_q  <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      reg1_q    <= reg1_d;
      reg2_q    <= reg2_d;
      sel_q     <= sel_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign instr_ready = ready_q;
  assign reg1        = reg1_q;
  assign reg2        = reg2_q;
  assign ALU_sel     = sel_q;
  assign done        = done_q;
  assign illegal     = illegal_q;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning operand/result width; only 16 is supported.
REQ-002 SHALL have parameter NREGS, default 8, meaning register-file depth; only 8 is supported.
REQ-003 SHALL have port clk, input, 1, meaning the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port instr_valid, input, 1, meaning instr holds a valid instruction.
REQ-006 SHALL have port instr, input, 16, with fields op[15:13], rd[12:10], ra[9:7], rb[6:4] and imm[9:0].
REQ-007 SHALL have port instr_ready, output, 1, meaning the block can accept an instruction.
REQ-008 SHALL have port reg1, output, 16, meaning ALU operand A.
REQ-009 SHALL have port reg2, output, 16, meaning ALU operand B.
REQ-010 SHALL have port ALU_sel, output, 3, meaning ALU opcode: 000 add, 001 sub, 010 nand.
REQ-011 SHALL have port alu_out, input, 16, meaning the combinational ALU result.
REQ-012 SHALL have port done, output, 1, meaning a one-cycle completion pulse.
REQ-013 SHALL have port illegal, output, 1, meaning a one-cycle pulse for an unsupported opcode.
REQ-014 SHALL have port dbg_addr, input, 3, meaning the debug read address.
REQ-015 SHALL have port dbg_data, output, 16, meaning the combinational register-file read at dbg_addr.

Function
REQ-016 SHALL implement the FSM states IDLE, READ, EXEC and WB.
REQ-017 SHALL drive instr_ready=1 only in IDLE.
REQ-018 SHALL accept an instruction when instr_valid and instr_ready are both high at a rising edge: latch instr, then go IDLE->READ.
REQ-019 SHALL, in READ, register regfile[ra] and regfile[rb] into its operand registers, then go READ->EXEC.
REQ-020 SHALL, in EXEC, drive reg1/reg2 from the operand registers and ALU_sel=op[2:0], capture alu_out at the edge, then go EXEC->WB.
REQ-021 SHALL, in WB, write the captured result to regfile[rd], pulse done, then go WB->IDLE.
REQ-022 SHALL complete the sequence accept edge -> done high in exactly 3 cycles, with a maximum throughput of one instruction per 4 cycles.
REQ-023 SHALL treat op 011 (LDI) as capturing {6'b0, imm} in EXEC instead of alu_out; ALU_sel SHALL still be driven as 000.
REQ-024 SHALL treat op 100-111 as illegal: pulse illegal in WB, perform no register write, assert no done.
REQ-025 SHALL hardwire r0 to zero: writes to r0 are discarded, but done still pulses.
REQ-026 SHALL drive reg1, reg2 and ALU_sel to 0 in all states other than EXEC.
REQ-027 SHALL ignore instr_valid outside IDLE; instr is not required to stay stable after acceptance.
REQ-028 SHALL return dbg_data with a WB write visible on the cycle after that WB cycle.
REQ-029 SHALL perform all arithmetic modulo 2^16; there are no flags.

Reset
REQ-030 SHALL, on rst_n low, immediately force the FSM to IDLE and clear all regfile entries, operand registers and the result register, with done=0, illegal=0, reg1=reg2=0 and ALU_sel=000.
REQ-031 SHALL, if reset is asserted mid-instruction, abandon that instruction with no write and no done.
REQ-032 SHALL drive instr_ready=1 from the first cycle after rst_n deasserts.

Structure
REQ-033 SHALL take the opcode constants (ADD, SUB, NAND, LDI) and the FSM state enum from the shared package cpu_pkg.
REQ-034 SHALL place the register file in a single sub-module alu_regfile (8x16, two combinational read ports plus the debug port, one synchronous write port, async reset).

Verification
REQ-035 SHALL cover the directed scenario: LDI r1,5; LDI r2,3; ADD r3,r1,r2 -> dbg r3=0x0008, done 3 cycles after each accept.
REQ-036 SHALL cover the directed scenario: SUB r4,r2,r1 with r1=5, r2=3 -> r4=0xFFFE (wrap-around).
REQ-037 SHALL cover the directed scenario: NAND r5,r0,r0 -> r5=0xFFFF; and LDI r0,0x3FF -> r0 reads 0 with done pulsed.
REQ-038 SHALL cover the directed scenario: op=101 -> illegal pulses once, done stays 0, all registers unchanged.
REQ-039 SHALL cover the directed scenario: instr_valid held high continuously -> instr_ready low in READ/EXEC/WB, exactly one accept per 4 cycles.
REQ-040 SHALL cover the directed scenario: rst_n pulsed low during EXEC of ADD r6 -> r6=0, no done, instr_ready=1 on the first cycle after release.
